spi_avalon_frame_bridge: RTL and testbench
==========================================

Name: spi_avalon_frame_bridge

Overview:
- Parametrised, table-free successor to the hard-coded SPI-frame-to-myocontrol sequencer.
- Buffers one SPI frame of bytes from the byte-level SPI slave, then runs a burst of Avalon-MM writes and/or reads over a {register, motor} address grid.
- Read results are queued for shift-out in the next frame.
- Sits between spi_slave and the myocontrol Avalon slave; adds a command header, length checks, waitrequest timeout and a status byte.

Parameters:
NUM_MOTORS, 4, motors per register row (1..256)
BYTES_PER_WORD, 4, bytes per Avalon word in frame (1..4)
MAX_WORDS, 32, max words per frame (1..255)
ADDR_W, 16, Avalon address width; [15:8]=register, [7:0]=motor
TIMEOUT, 255, max waitrequest-high cycles per transaction
SYNC_STAGES, 2, synchroniser depth for iFRAME_n

Ports:
iCLK  in  1  system clock
iRESET  in  1  reset; synchronous, active-high
iFRAME_n  in  1  frame select from SAMD pin, active low, asynchronous
iRX_VALID  in  1  spi_slave do_valid_o (level; rising edge = new byte)
iRX_DATA  in  8  spi_slave do_o
oTX_DATA  out  8  to spi_slave di_i
oTX_LOAD  out  1  to spi_slave wren_i; 1-cycle pulse
oAVM_ADDRESS  out  ADDR_W  Avalon address
oAVM_WRITE  out  1  Avalon write
oAVM_WRITEDATA  out  32  Avalon writedata
oAVM_READ  out  1  Avalon read
iAVM_READDATA  in  32  Avalon readdata
iAVM_WAITREQUEST  in  1  Avalon waitrequest
oBUSY  out  1  high outside IDLE/RECEIVE
oSTATUS  out  4  sticky-per-frame status (bit map below)

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, RX/TX buffers 0, status 0.
- iFRAME_n passes through SYNC_STAGES flops; frame start/end are edges of the synchronised signal. iRX_VALID rising edge is detected with one register.
- Frame format: byte0 CMD (bit0 DO_WRITE, bit1 DO_READ); byte1 BASE register; byte2 COUNT N; then N*BYTES_PER_WORD write bytes, little-endian.
- TX frame: byte0 = status of previous transaction; bytes 1.. = read data, little-endian. Indices past 1+MAX_WORDS*BYTES_PER_WORD send 0x00.
- IDLE:
  - On frame start, clear counter, drive oTX_DATA=TX[0], pulse oTX_LOAD, go to RECEIVE.
  - A frame start while oBUSY=1 is ignored. Its bytes are dropped and status bit3 (BUSY_DROP) is set for the next report.
- RECEIVE:
  - On each RX edge, store RX[cnt] and increment cnt (saturating).
  - The cycle after the edge, present TX[cnt] and pulse oTX_LOAD.
  - Bytes beyond 3+MAX_WORDS*BYTES_PER_WORD are discarded and set bit1 (OVERFLOW).
  - On frame end, go to CHECK.
- CHECK (1 cycle): length error (bit2) if any of:
  - cnt<3
  - N==0 or N>MAX_WORDS
  - DO_WRITE and cnt<3+N*BYTES_PER_WORD
  - On error go to DONE with no Avalon traffic. Else go to WRITE if DO_WRITE, READ if DO_READ, otherwise DONE.
- Word k addressing:
  - reg = (BASE + k div NUM_MOTORS) mod 256; motor = k mod NUM_MOTORS.
  - Use incrementing reg/motor counters; no divider.
  - Address = {reg, motor}, zero-extended or truncated to ADDR_W.
- WRITE:
  - Load address and writedata (word k bytes, zero-extended to 32 b), then assert oAVM_WRITE.
  - WAIT_W holds all signals while waitrequest=1. Drop write the cycle waitrequest=0 is sampled.
  - After word N-1, go to READ if DO_READ, else DONE.
- READ / WAIT_R:
  - Same address sequence, with oAVM_READ held until waitrequest=0.
  - On that cycle, capture the low BYTES_PER_WORD bytes of readdata into TX[1+k*BYTES_PER_WORD ..].
  - After word N-1, go to DONE. TX data is left unchanged if DO_READ=0.
- Timeout:
  - Waitrequest high for TIMEOUT consecutive cycles deasserts write/read, sets bit0 (TIMEOUT) and goes to DONE. Remaining words are skipped.
- DONE (1 cycle): copy status into TX[0] and oSTATUS, clear working flags, go to IDLE.
  - Within DONE, a BUSY_DROP event for the current cycle is kept for the next report.
- One Avalon transaction is outstanding at a time. Write and read are never high together. Minimum 2 cycles per word.
- Reset mid-transaction: outputs return to 0 on the next clock edge; the partial frame is lost.

Test Plan:
- Reset, then frame {03,00,04, 16 bytes 01..10}, slave waitrequest=0:
  - 4 writes: addr 0000/0001/0002/0003, data 04030201, 08070605, ...
  - Then 4 reads at the same addresses.
  - Next frame returns 00 followed by the read bytes.
- NUM_MOTORS=4, frame {02,05,06}:
  - Read addresses 0500, 0501, 0502, 0503, 0600, 0601.
  - BASE=FF wraps the row to 00.
- Waitrequest held 3 cycles per transaction: each strobe is held exactly 3+1 cycles with stable address/data, and status is 00.
- Waitrequest stuck high with TIMEOUT=255: strobe drops after 255 cycles, no further words run, and the next TX byte0 = 01.
- Frame {01,00,02} plus 3 data bytes: no Avalon traffic and status 04. A frame of 200 bytes sets status bit1.
- Frame start asserted during WRITE of a 32-word burst: that frame is ignored, and the following report has bit3 set (08).

Source files
------------

// File: rtl/spi_avalon_frame_bridge.sv
// Buffers one SPI frame of bytes, then replays it as a burst of Avalon-MM writes
// and/or reads over a {register, motor} grid; read data and a status byte go out in the next frame.
module spi_avalon_frame_bridge #(
    parameter int NUM_MOTORS     = 4,
    parameter int BYTES_PER_WORD = 4,
    parameter int MAX_WORDS      = 32,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT        = 255,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iFRAME_n,
    input  logic              iRX_VALID,
    input  logic [7:0]        iRX_DATA,
    output logic [7:0]        oTX_DATA,
    output logic              oTX_LOAD,
    output logic [ADDR_W-1:0] oAVM_ADDRESS,
    output logic              oAVM_WRITE,
    output logic [31:0]       oAVM_WRITEDATA,
    output logic              oAVM_READ,
    input  logic [31:0]       iAVM_READDATA,
    input  logic              iAVM_WAITREQUEST,
    output logic              oBUSY,
    output logic [3:0]        oSTATUS
);
    localparam int RX_LEN    = 3 + MAX_WORDS * BYTES_PER_WORD;
    localparam int TX_LEN    = 1 + MAX_WORDS * BYTES_PER_WORD;
    localparam int CW        = $clog2(RX_LEN + 1);
    localparam int BUF_DEPTH = 1 << CW;
    localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RECEIVE, S_CHECK, S_WRITE, S_WAIT_W, S_READ, S_WAIT_R, S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [SYNC_STAGES-1:0] frame_sync_reg;
    logic                frame_prev_reg;
    logic                rx_valid_reg;
    logic [CW-1:0]       cnt_reg;
    logic [7:0]          rx_buf [BUF_DEPTH];
    logic [7:0]          tx_buf [BUF_DEPTH];
    logic [7:0]          tx_data_reg;
    logic                tx_load_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [31:0]         wdata_reg;
    logic [3:0]          status_reg;
    logic [3:0]          status_out_reg;
    logic [7:0]          row_reg, motor_reg, word_reg;
    logic [CW-1:0]       wptr_reg, tptr_reg;
    logic [TW-1:0]       to_cnt_reg;

    // Metastability chain for the asynchronous frame select
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge iCLK) begin
                if (iRESET)
                    frame_sync_reg[gi] <= 1'b1;
                else if (gi == 0)
                    frame_sync_reg[gi] <= iFRAME_n;
                else
                    frame_sync_reg[gi] <= frame_sync_reg[(gi > 0) ? gi - 1 : 0];
            end
        end
    endgenerate

    logic frame_n_s, frame_start, frame_end, rx_edge;
    assign frame_n_s   = frame_sync_reg[SYNC_STAGES-1];
    assign frame_start = frame_prev_reg & ~frame_n_s;
    assign frame_end   = ~frame_prev_reg & frame_n_s;
    assign rx_edge     = iRX_VALID & ~rx_valid_reg;

    logic [7:0]  cmd, base, num;
    logic [11:0] need_len;
    logic        len_err, last_word, wait_hi, timed_out, advance, restart;
    logic [CW-1:0] cnt_inc;
    logic [7:0]  tx_next;
    logic [31:0] word_wdata;

    assign cmd       = rx_buf[0];
    assign base      = rx_buf[1];
    assign num       = rx_buf[2];
    assign need_len  = 12'd3 + {4'd0, num} * 12'(BYTES_PER_WORD);
    assign len_err   = (cnt_reg < CW'(3)) || (num == 8'd0) || ({4'd0, num} > 12'(MAX_WORDS)) ||
                       (cmd[0] && (12'(cnt_reg) < need_len));
    assign last_word = (word_reg == num - 8'd1);
    assign wait_hi   = iAVM_WAITREQUEST;
    assign timed_out = wait_hi && (to_cnt_reg == TW'(TIMEOUT - 1));
    assign advance   = ((state_reg == S_WAIT_W) || (state_reg == S_WAIT_R)) && !wait_hi;
    // Counters rewind at the start of each phase so reads reuse the write address sequence
    assign restart   = (state_reg == S_CHECK) || ((state_reg == S_WAIT_W) && !wait_hi && last_word);
    assign cnt_inc   = (cnt_reg == CW'(RX_LEN)) ? cnt_reg : cnt_reg + CW'(1);
    assign tx_next   = (cnt_inc < CW'(TX_LEN)) ? tx_buf[cnt_inc] : 8'h00;

    always_comb begin
        word_wdata = '0;
        for (int b = 0; b < BYTES_PER_WORD; b++)
            word_wdata[8*b +: 8] = rx_buf[wptr_reg + CW'(b)];
    end

    always_ff @(posedge iCLK) begin
        if (iRESET)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        oAVM_WRITE = 1'b0;
        oAVM_READ  = 1'b0;
        oBUSY      = 1'b1;
        case (state_reg)
            S_IDLE: begin
                oBUSY = 1'b0;
                if (frame_start) state_next = S_RECEIVE;
            end
            S_RECEIVE: begin
                oBUSY = 1'b0;
                if (frame_end) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (len_err)     state_next = S_DONE;
                else if (cmd[0]) state_next = S_WRITE;
                else if (cmd[1]) state_next = S_READ;
                else             state_next = S_DONE;
            end
            S_WRITE: state_next = S_WAIT_W;
            S_WAIT_W: begin
                oAVM_WRITE = 1'b1;
                if (wait_hi) begin
                    if (timed_out) state_next = S_DONE;
                end else if (last_word) begin
                    state_next = cmd[1] ? S_READ : S_DONE;
                end else begin
                    state_next = S_WRITE;
                end
            end
            S_READ: state_next = S_WAIT_R;
            S_WAIT_R: begin
                oAVM_READ = 1'b1;
                if (wait_hi) begin
                    if (timed_out) state_next = S_DONE;
                end else begin
                    state_next = last_word ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            frame_prev_reg <= 1'b1;
            rx_valid_reg   <= 1'b0;
            cnt_reg        <= '0;
            tx_data_reg    <= '0;
            tx_load_reg    <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            status_reg     <= '0;
            status_out_reg <= '0;
            row_reg        <= '0;
            motor_reg      <= '0;
            word_reg       <= '0;
            wptr_reg       <= '0;
            tptr_reg       <= '0;
            to_cnt_reg     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                rx_buf[i] <= '0;
                tx_buf[i] <= '0;
            end
        end else begin
            frame_prev_reg <= frame_n_s;
            rx_valid_reg   <= iRX_VALID;
            tx_load_reg    <= 1'b0;
            if (frame_start && oBUSY && (state_reg != S_DONE))
                status_reg[3] <= 1'b1;

            if (restart) begin
                row_reg   <= base;
                motor_reg <= '0;
                word_reg  <= '0;
                wptr_reg  <= CW'(3);
                tptr_reg  <= CW'(1);
            end else if (advance) begin
                word_reg <= word_reg + 8'd1;
                wptr_reg <= wptr_reg + CW'(BYTES_PER_WORD);
                tptr_reg <= tptr_reg + CW'(BYTES_PER_WORD);
                if (motor_reg == 8'(NUM_MOTORS - 1)) begin
                    motor_reg <= '0;
                    row_reg   <= row_reg + 8'd1;
                end else begin
                    motor_reg <= motor_reg + 8'd1;
                end
            end

            case (state_reg)
                S_IDLE: if (frame_start) begin
                    cnt_reg     <= '0;
                    tx_data_reg <= tx_buf[0];
                    tx_load_reg <= 1'b1;
                end
                S_RECEIVE: if (rx_edge) begin
                    if (cnt_reg == CW'(RX_LEN))
                        status_reg[1] <= 1'b1;
                    else
                        rx_buf[cnt_reg] <= iRX_DATA;
                    cnt_reg     <= cnt_inc;
                    tx_data_reg <= tx_next;
                    tx_load_reg <= 1'b1;
                end
                S_CHECK: if (len_err) status_reg[2] <= 1'b1;
                S_WRITE, S_READ: begin
                    addr_reg   <= ADDR_W'({row_reg, motor_reg});
                    wdata_reg  <= (state_reg == S_WRITE) ? word_wdata : 32'd0;
                    to_cnt_reg <= '0;
                end
                S_WAIT_W, S_WAIT_R: begin
                    if (wait_hi) begin
                        if (timed_out) status_reg[0] <= 1'b1;
                        else           to_cnt_reg <= to_cnt_reg + TW'(1);
                    end else if (state_reg == S_WAIT_R) begin
                        for (int b = 0; b < BYTES_PER_WORD; b++)
                            tx_buf[tptr_reg + CW'(b)] <= iAVM_READDATA[8*b +: 8];
                    end
                end
                S_DONE: begin
                    tx_buf[0]      <= {4'd0, status_reg};
                    status_out_reg <= status_reg;
                    // A drop seen during this very cycle belongs to the next report
                    status_reg     <= {frame_start, 3'b000};
                end
                default: ;
            endcase
        end
    end

    assign oTX_DATA       = tx_data_reg;
    assign oTX_LOAD       = tx_load_reg;
    assign oAVM_ADDRESS   = addr_reg;
    assign oAVM_WRITEDATA = wdata_reg;
    assign oSTATUS        = status_out_reg;
endmodule

// File: tb/tb_spi_avalon_frame_bridge.sv
// Randomised and directed frames against a frame-level reference model of the bridge.
module tb_spi_avalon_frame_bridge;
    localparam int NM = 4, BPW = 4, MW = 32, AW = 16, TO = 255, SS = 2;
    localparam int RXL = 3 + MW * BPW;
    localparam int TXL = 1 + MW * BPW;

    logic          iCLK = 1'b0;
    logic          iRESET = 1'b1;
    logic          iFRAME_n = 1'b1;
    logic          iRX_VALID = 1'b0;
    logic [7:0]    iRX_DATA = '0;
    logic [7:0]    oTX_DATA;
    logic          oTX_LOAD;
    logic [AW-1:0] oAVM_ADDRESS;
    logic          oAVM_WRITE;
    logic [31:0]   oAVM_WRITEDATA;
    logic          oAVM_READ;
    logic [31:0]   iAVM_READDATA = '0;
    logic          iAVM_WAITREQUEST = 1'b0;
    logic          oBUSY;
    logic [3:0]    oSTATUS;

    spi_avalon_frame_bridge #(
        .NUM_MOTORS(NM), .BYTES_PER_WORD(BPW), .MAX_WORDS(MW),
        .ADDR_W(AW), .TIMEOUT(TO), .SYNC_STAGES(SS)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iFRAME_n(iFRAME_n), .iRX_VALID(iRX_VALID),
        .iRX_DATA(iRX_DATA), .oTX_DATA(oTX_DATA), .oTX_LOAD(oTX_LOAD),
        .oAVM_ADDRESS(oAVM_ADDRESS), .oAVM_WRITE(oAVM_WRITE), .oAVM_WRITEDATA(oAVM_WRITEDATA),
        .oAVM_READ(oAVM_READ), .iAVM_READDATA(iAVM_READDATA),
        .iAVM_WAITREQUEST(iAVM_WAITREQUEST), .oBUSY(oBUSY), .oSTATUS(oSTATUS)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [15:0] len;
    } txn_t;

    int total = 0, bad = 0;
    txn_t got_q[$], exp_q[$];
    logic [7:0] tx_got[$], frame_q[$];
    logic [31:0] slave_mem [int];
    logic [31:0] ref_mem [int];
    logic [7:0]  ref_tx [TXL];
    int wait_n = 0, hold = 0, last_len = 0, stab_err = 0, proto_err = 0;
    bit stuck = 1'b0;
    logic [15:0] h_addr;
    logic [31:0] h_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input int a);
        return {8'(a) ^ 8'hA5, 8'(a >> 8), 8'(a) ^ 8'h3C, 8'h77};
    endfunction

    // Avalon slave with programmable waitrequest length, plus TX-load and handshake monitor
    always @(negedge iCLK) begin
        txn_t t;
        if (oTX_LOAD) tx_got.push_back(oTX_DATA);
        if (oAVM_WRITE && oAVM_READ) proto_err++;
        if (oAVM_WRITE || oAVM_READ) begin
            if (hold == 0) begin
                h_addr = oAVM_ADDRESS;
                h_data = oAVM_WRITEDATA;
            end else if (oAVM_ADDRESS !== h_addr || (oAVM_WRITE && oAVM_WRITEDATA !== h_data)) begin
                stab_err++;
            end
            hold++;
            iAVM_WAITREQUEST = stuck || (hold <= wait_n);
            iAVM_READDATA = slave_mem.exists(int'(oAVM_ADDRESS)) ? slave_mem[int'(oAVM_ADDRESS)]
                                                                   : dflt(int'(oAVM_ADDRESS));
            if (!iAVM_WAITREQUEST) begin
                t.wr   = oAVM_WRITE;
                t.addr = oAVM_ADDRESS;
                t.data = oAVM_WRITE ? oAVM_WRITEDATA : iAVM_READDATA;
                t.len  = 16'(hold);
                got_q.push_back(t);
                if (oAVM_WRITE) slave_mem[int'(oAVM_ADDRESS)] = oAVM_WRITEDATA;
            end
        end else begin
            if (hold != 0) last_len = hold;
            hold = 0;
            iAVM_WAITREQUEST = 1'b0;
        end
    end

    // Frame-level reference: decides status, expected transactions and the next TX image
    task automatic model_frame(input bit stk, input bit inject, output logic [7:0] st);
        int L, c, n, a;
        logic [7:0] cmd, base;
        logic [31:0] d;
        bit err;
        st = 8'h00;
        L = frame_q.size();
        c = (L > RXL) ? RXL : L;
        if (L > RXL) st |= 8'h02;
        err = 1'b0;
        cmd = 8'h00; base = 8'h00; n = 0;
        if (c < 3) err = 1'b1;
        else begin
            cmd = frame_q[0]; base = frame_q[1]; n = int'(frame_q[2]);
            if (n == 0 || n > MW) err = 1'b1;
            if (cmd[0] && c < 3 + n * BPW) err = 1'b1;
        end
        if (err) st |= 8'h04;
        else if (stk && (cmd[0] || cmd[1])) st |= 8'h01;
        else begin
            if (cmd[0])
                for (int k = 0; k < n; k++) begin
                    a = ((int'(base) + k / NM) % 256) * 256 + (k % NM);
                    d = '0;
                    for (int b = 0; b < BPW; b++) d |= 32'(frame_q[3 + k * BPW + b]) << (8 * b);
                    exp_q.push_back({1'b1, 16'(a), d, 16'd0});
                    ref_mem[a] = d;
                end
            if (cmd[1])
                for (int k = 0; k < n; k++) begin
                    a = ((int'(base) + k / NM) % 256) * 256 + (k % NM);
                    d = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                    exp_q.push_back({1'b0, 16'(a), d, 16'd0});
                    for (int b = 0; b < BPW; b++) ref_tx[1 + k * BPW + b] = 8'(d >> (8 * b));
                end
        end
        if (inject) st |= 8'h08;
        ref_tx[0] = st;
    endtask

    task automatic frame_begin();
        @(negedge iCLK) iFRAME_n = 1'b0;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        iRX_DATA = b;
        iRX_VALID = 1'b1;
        @(negedge iCLK) iRX_VALID = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic frame_finish();
        repeat (2) @(negedge iCLK);
        iFRAME_n = 1'b1;
    endtask

    task automatic do_frame(input string name, input int wn, input bit stk, input bit inject);
        logic [7:0] exp_tx[$];
        logic [7:0] st;
        int L, idx, m;
        L = frame_q.size();
        for (int i = 0; i <= L; i++) begin
            idx = (i > RXL) ? RXL : i;
            exp_tx.push_back((idx < TXL) ? ref_tx[idx] : 8'h00);
        end
        exp_q.delete(); got_q.delete(); tx_got.delete();
        model_frame(stk, inject, st);
        wait_n = wn; stuck = stk;
        frame_begin();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        frame_finish();
        repeat (10) @(negedge iCLK);
        if (inject) begin
            check({name, "_busy_at_drop"}, 32'(oBUSY), 32'd1);
            frame_begin();
            send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
            frame_finish();
        end
        for (int i = 0; i < 5000 && oBUSY; i++) @(negedge iCLK);
        check({name, "_idle"}, 32'(oBUSY), 32'd0);
        check({name, "_txload_cnt"}, 32'(tx_got.size()), 32'(exp_tx.size()));
        m = (tx_got.size() < exp_tx.size()) ? tx_got.size() : exp_tx.size();
        for (int i = 0; i < m; i++) check($sformatf("%s_tx%0d", name, i), 32'(tx_got[i]), 32'(exp_tx[i]));
        check({name, "_txn_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_t%0d_kind", name, i), 32'(got_q[i].wr), 32'(exp_q[i].wr));
            check($sformatf("%s_t%0d_addr", name, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s_t%0d_data", name, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_t%0d_len", name, i), 32'(got_q[i].len), 32'(wn + 1));
        end
        if (stk) check({name, "_timeout_len"}, 32'(last_len), 32'(TO));
        check({name, "_status"}, 32'(oSTATUS), 32'(st));
        $display("frame %s: len=%0d txns=%0d status=%h", name, L, got_q.size(), oSTATUS);
        stuck = 1'b0;
        repeat (3) @(negedge iCLK);
    endtask

    initial begin
        int n, nd;
        logic [7:0] cmd;
        for (int i = 0; i < TXL; i++) ref_tx[i] = 8'h00;
        repeat (4) @(negedge iCLK);
        check("rst_txdata", 32'(oTX_DATA), 32'd0);
        check("rst_txload", 32'(oTX_LOAD), 32'd0);
        check("rst_addr", 32'(oAVM_ADDRESS), 32'd0);
        check("rst_wr_rd", {30'd0, oAVM_WRITE, oAVM_READ}, 32'd0);
        check("rst_wdata", oAVM_WRITEDATA, 32'd0);
        check("rst_busy_status", {27'd0, oBUSY, oSTATUS}, 32'd0);
        iRESET = 1'b0;
        repeat (3) @(negedge iCLK);

        frame_q = {8'h03, 8'h00, 8'h04};
        for (int i = 1; i <= 16; i++) frame_q.push_back(8'(i));
        do_frame("wr_rd", 0, 1'b0, 1'b0);
        frame_q = {8'h02, 8'h05, 8'h06};
        do_frame("rd_grid", 0, 1'b0, 1'b0);
        frame_q = {8'h02, 8'hFF, 8'h06};
        do_frame("rd_wrap", 0, 1'b0, 1'b0);
        frame_q = {8'h03, 8'h10, 8'h03};
        for (int i = 0; i < 12; i++) frame_q.push_back(8'($urandom));
        do_frame("wait3", 3, 1'b0, 1'b0);
        frame_q = {8'h01, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
        do_frame("stuck", 0, 1'b1, 1'b0);
        frame_q = {8'h01, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03};
        do_frame("short", 0, 1'b0, 1'b0);
        frame_q = {8'h01, 8'h20, 8'h20};
        for (int i = 3; i < 200; i++) frame_q.push_back(8'($urandom));
        do_frame("overflow", 0, 1'b0, 1'b0);
        frame_q = {8'h01, 8'h00, 8'h20};
        for (int i = 0; i < 128; i++) frame_q.push_back(8'($urandom));
        do_frame("drop", 1, 1'b0, 1'b1);

        for (int r = 0; r < 12; r++) begin
            cmd = 8'($urandom_range(0, 3));
            n = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : MW + 1)
                                             : $urandom_range(1, 8);
            frame_q = {cmd, 8'($urandom), 8'(n)};
            nd = cmd[0] ? n * BPW - int'($urandom_range(0, 3) == 0) : $urandom_range(0, 2);
            for (int i = 0; i < nd; i++) frame_q.push_back(8'($urandom));
            do_frame($sformatf("rand%0d", r), $urandom_range(0, 2), 1'b0, 1'b0);
        end
        frame_q = {8'h00, 8'h00, 8'h00};
        do_frame("final", 0, 1'b0, 1'b0);

        check("rw_overlap", 32'(proto_err), 32'd0);
        check("strobe_stable", 32'(stab_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
